key_event_gen: RTL and testbench



---
 rtl/key_event_pkg.sv | 40 ++++
 rtl/key_event_ch.sv | 202 ++++++++++++++++++++
 rtl/key_event_gen.sv | 74 +++++++
 tb/tb_key_event_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
//
// Purpose:
//   Shared definitions for the front-panel key conditioner. This package holds
//   the per-channel state encoding, the default cycle constants, and a helper
//   that says which states count as "key accepted as down".
//
// Contents:
//   key_state_e            per-channel FSM states
//   DEF_*                  default parameter values for key_event_gen
//   state_is_held()        1 for PRESSED / REPEAT / DB_UP
//
// Configuration:
//   The macro KEY_EVENT_REPEAT_EN is not used in this package. It only
//   affects key_event_ch and key_event_gen.
// -----------------------------------------------------------------------------
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DB_DOWN = 3'd1,
    PRESSED = 3'd2,
    REPEAT  = 3'd3,
    DB_UP   = 3'd4
  } key_state_e;

  localparam int DEF_N_KEYS        = 4;
  localparam int DEF_CNT_W         = 24;
  localparam int DEF_DEB_CYCLES    = 20000;
  localparam int DEF_HOLD_CYCLES   = 1500000;
  localparam int DEF_REPEAT_CYCLES = 300000;

  // DB_UP still reports the key as down. A release is only believed once it
  // has been stable for the full debounce window.
  function automatic logic state_is_held(key_state_e s);
    return (s == PRESSED) || (s == REPEAT) || (s == DB_UP);
  endfunction

endpackage

// File: rtl/key_event_ch.sv
// -----------------------------------------------------------------------------
// key_event_ch
//
// Purpose:
//   This module conditions one front-panel key. It does three things:
//     - synchronizes the raw active-low level with a 2-flop synchronizer;
//     - debounces the press and the release;
//     - generates one-cycle press, long-press, auto-repeat and release
//       strobes, plus a held level.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_key_n    raw key level, 0 = pressed, asynchronous to i_clk
//   i_enable   1 = channel runs; 0 = channel forced idle
//   o_press    1-cycle strobe on accepted press
//   o_long     1-cycle strobe when the hold threshold is reached
//   o_repeat   1-cycle auto-repeat strobe (tied 0 without KEY_EVENT_REPEAT_EN)
//   o_release  1-cycle strobe on accepted release
//   o_held     level, key accepted as down
//
// Configuration:
//   KEY_EVENT_REPEAT_EN  When this macro is defined, REPEAT emits periodic
//                        o_repeat strobes, and the first strobe lands together
//                        with o_long. When it is undefined, REPEAT is a silent
//                        hold state that lasts until release.
// -----------------------------------------------------------------------------
module key_event_ch
  import key_event_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  input  logic i_enable,
  output logic o_press,
  output logic o_long,
  output logic o_repeat,
  output logic o_release,
  output logic o_held
);

  // Terminal counts. The counter runs from 0 up to one of these values and
  // never goes past it.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`else
  // The repeat period has no effect in this build. It is collected here so
  // that its absence from the logic is explicit.
  logic [31:0] unused_repeat_cycles;
  assign unused_repeat_cycles = 32'(REPEAT_CYCLES);
`endif

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  key_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       press_q, press_d;
  logic       long_q, long_d;
  logic       repeat_q, repeat_d;
  logic       release_q, release_d;
  logic       pressed;

  // While the channel is disabled, the synchronizer is parked at "released".
  // A key that is still held when enable returns must then re-enter through
  // the full synchronizer + debounce path. As a result, the press latency
  // after re-enable matches the latency after reset.
  always_comb begin
    sync1_d = 1'b1;
    sync2_d = 1'b1;
    if (i_enable) begin
      sync1_d = i_key_n;
      sync2_d = sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;

    if (!i_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (pressed) state_d = DB_DOWN;
        end

        DB_DOWN: begin
          if (!pressed) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        PRESSED: begin
          if (!pressed) begin
            state_d = DB_UP;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = REPEAT;
            cnt_d   = '0;
            long_d  = 1'b1;
`ifdef KEY_EVENT_REPEAT_EN
            repeat_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        REPEAT: begin
          if (!pressed) begin
            state_d = DB_UP;
            cnt_d   = '0;
          end else begin
`ifdef KEY_EVENT_REPEAT_EN
            if (cnt_q == REP_LAST) begin
              cnt_d    = '0;
              repeat_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
`else
            cnt_d = '0;
`endif
          end
        end

        // If the key goes down again during the release window, it is
        // treated as contact bounce. The key stays held, no new press is
        // reported, and the hold timer starts over.
        DB_UP: begin
          if (pressed) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
    end
  end

  assign o_press   = press_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_release = release_q;
  assign o_held    = state_is_held(state_q);

endmodule

// File: rtl/key_event_gen.sv
// -----------------------------------------------------------------------------
// key_event_gen
//
// Purpose:
//   Front-panel key conditioner that feeds the menu / equalizer control logic.
//   It holds N_KEYS independent key_event_ch channels. It also forms o_event,
//   a single "something to act on" strobe that covers presses and
//   auto-repeats.
//
// Ports:
//   i_clk      system clock (audio bit clock domain)
//   i_rst_n    asynchronous active-low reset
//   i_key_n    raw key levels, 0 = pressed, asynchronous to i_clk
//   i_enable   1 = channels run; 0 = channels forced idle
//   o_press    per-key 1-cycle strobe on accepted press
//   o_long     per-key 1-cycle strobe when the hold threshold is reached
//   o_repeat   per-key 1-cycle auto-repeat strobes
//   o_release  per-key 1-cycle strobe on accepted release
//   o_held     per-key level, key accepted as down
//   o_event    OR of all o_press and o_repeat bits, in the same cycle
//
// Configuration:
//   KEY_EVENT_REPEAT_EN  Define this macro to enable auto-repeat. Without it,
//                        o_repeat stays 0 and o_event reflects presses only.
// -----------------------------------------------------------------------------
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int N_KEYS        = DEF_N_KEYS,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key_n,
  input  logic              i_enable,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_held,
  output logic              o_event
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_event_ch #(
      .CNT_W        (CNT_W),
      .DEB_CYCLES   (DEB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key_n  (i_key_n[g]),
      .i_enable (i_enable),
      .o_press  (o_press[g]),
      .o_long   (o_long[g]),
      .o_repeat (o_repeat[g]),
      .o_release(o_release[g]),
      .o_held   (o_held[g])
    );
  end

  // The strobes are already registered. o_event is built from them directly,
  // so it lines up exactly with the per-key bits and needs no flop of its own.
`ifdef KEY_EVENT_REPEAT_EN
  assign o_event = |(o_press | o_repeat);
`else
  assign o_event = |o_press;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// -----------------------------------------------------------------------------
// tb_key_event_gen
//
// Self-checking bench for key_event_gen, built with small cycle constants.
// An event-level reference model runs alongside the DUT. It tracks how long
// each key has been seen down or up and how long it has been held, and every
// DUT output is compared against it on each falling clock edge. Directed
// scenarios add hand-computed literal expectations. Randomized key bounce,
// enable drops and reset pulses follow the directed scenarios.
// Honors KEY_EVENT_REPEAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_key_event_gen;

  localparam int N      = 4;
  localparam int DEB    = 4;
  localparam int HOLD   = 20;
  localparam int REP    = 8;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] key_n;
  logic         enable;
  logic [N-1:0] o_press, o_long, o_repeat, o_release, o_held;
  logic         o_event;

  int checks;
  int failures;
  bit cmp_en;

  key_event_gen #(
    .N_KEYS       (N),
    .CNT_W        (8),
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_key_n  (key_n),
    .i_enable (enable),
    .o_press  (o_press),
    .o_long   (o_long),
    .o_repeat (o_repeat),
    .o_release(o_release),
    .o_held   (o_held),
    .o_event  (o_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model.
  // The raw key is seen after a two-sample delay line, which is parked at
  // "released" while the block is disabled.
  // A press is accepted once the key has been seen down DEB+1 edges in a row.
  // A release is accepted once the key has been seen up DEB+1 edges in a row.
  // Long press fires HOLD edges after the key was accepted, or after it came
  // back during the release window. Repeats then follow every REP edges.
  // ---------------------------------------------------------------------------
  logic [N-1:0] dly0, dly1;
  logic [N-1:0] m_held;
  int           down_run [N];
  int           up_run   [N];
  int           hold_age [N];
  int           rep_age  [N];
  bit           long_done[N];
  logic [N-1:0] e_press, e_long, e_repeat, e_release, e_held;
  logic         e_event;

  task automatic model_reset();
    dly0 = '1;
    dly1 = '1;
    m_held = '0;
    for (int k = 0; k < N; k++) begin
      down_run[k] = 0; up_run[k] = 0; hold_age[k] = 0; rep_age[k] = 0;
      long_done[k] = 1'b0;
    end
    e_press = '0; e_long = '0; e_repeat = '0; e_release = '0;
    e_held = '0; e_event = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] p;
    p = ~dly1;
    e_press = '0; e_long = '0; e_repeat = '0; e_release = '0;
    if (!enable) begin
      model_reset();
    end else begin
      dly1 = dly0;
      dly0 = key_n;
      for (int k = 0; k < N; k++) begin
        if (!m_held[k]) begin
          if (p[k]) begin
            down_run[k]++;
            if (down_run[k] == DEB + 1) begin
              e_press[k] = 1'b1;
              m_held[k] = 1'b1;
              down_run[k] = 0; up_run[k] = 0; hold_age[k] = 0;
              long_done[k] = 1'b0;
            end
          end else begin
            down_run[k] = 0;
          end
        end else if (!p[k]) begin
          up_run[k]++;
          if (up_run[k] == DEB + 1) begin
            e_release[k] = 1'b1;
            m_held[k] = 1'b0;
            up_run[k] = 0;
          end
        end else if (up_run[k] != 0) begin
          up_run[k] = 0; hold_age[k] = 0; long_done[k] = 1'b0;
        end else if (!long_done[k]) begin
          hold_age[k]++;
          if (hold_age[k] == HOLD) begin
            e_long[k] = 1'b1;
            e_repeat[k] = REP_EN;
            long_done[k] = 1'b1;
            rep_age[k] = 0;
          end
        end else if (REP_EN) begin
          rep_age[k]++;
          if (rep_age[k] == REP) begin
            e_repeat[k] = 1'b1;
            rep_age[k] = 0;
          end
        end
      end
    end
    e_held  = m_held;
    e_event = |(e_press | e_repeat);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers.
  // ---------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] keys, input logic en);
    @(negedge clk);
    key_n  = keys;
    enable = en;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_press"},   32'(o_press),   32'h0);
    checkOutput({tag, "_long"},    32'(o_long),    32'h0);
    checkOutput({tag, "_repeat"},  32'(o_repeat),  32'h0);
    checkOutput({tag, "_release"}, 32'(o_release), 32'h0);
    checkOutput({tag, "_held"},    32'(o_held),    32'h0);
    checkOutput({tag, "_event"},   32'(o_event),   32'h0);
  endtask

  // The model is compared against the DUT on every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        checkOutput("m_press",   32'(o_press),   32'(e_press));
        checkOutput("m_long",    32'(o_long),    32'(e_long));
        checkOutput("m_repeat",  32'(o_repeat),  32'(e_repeat));
        checkOutput("m_release", 32'(o_release), 32'(e_release));
        checkOutput("m_held",    32'(o_held),    32'(e_held));
        checkOutput("m_event",   32'(o_event),   32'(e_event));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus.
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] base;
    logic [N-1:0] drv;
    logic         en;
    int           dis_left;
    int           n_press1;
    int           n_strobe1;
    bit           rst_pend;

    checks = 0; failures = 0; cmp_en = 1'b0;
    rst_n = 1'b0; key_n = '1; enable = 1'b1;
    repeat (3) @(negedge clk);
    #1 checkAllZero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    repeat (8) applyStimulus('1, 1'b1);

    // Clean press / long hold / repeats / release on key 0.
    // The key is down from edge 0 and released before edge 60.
    applyStimulus(4'b1110, 1'b1);
    for (int j = 0; j < 76; j++) begin
      applyStimulus((j >= 59) ? 4'b1111 : 4'b1110, 1'b1);
      if (j >= 5 && j <= 7)
        checkOutput("clean_press", 32'(o_press), (j == 6) ? 32'h1 : 32'h0);
      if (j == 5 || j == 6)
        checkOutput("clean_held_on", 32'(o_held), (j == 6) ? 32'h1 : 32'h0);
      if (j == 25 || j == 26)
        checkOutput("long_at_26", 32'(o_long), (j == 26) ? 32'h1 : 32'h0);
      if (j == 26 || j == 34 || j == 58)
        checkOutput("repeat_slot", 32'(o_repeat), REP_EN ? 32'h1 : 32'h0);
      if (j == 65 || j == 66) begin
        checkOutput("release_at_66", 32'(o_release), (j == 66) ? 32'h1 : 32'h0);
        checkOutput("held_off_66", 32'(o_held), (j == 66) ? 32'h0 : 32'h1);
      end
    end

    // Bounce on key 1. The key is low on edges 0 and 1, high on edge 2, then
    // low again until edge 30.
    n_press1 = 0;
    applyStimulus(4'b1101, 1'b1);
    for (int j = 0; j < 42; j++) begin
      applyStimulus(((j + 1) != 2 && (j + 1) <= 30) ? 4'b1101 : 4'b1111, 1'b1);
      if (o_press[1]) n_press1++;
      if (j == 9) checkOutput("bounce_press_9", 32'(o_press), 32'h2);
    end
    checkOutput("bounce_press_count", 32'(n_press1), 32'd1);

    // A 3-cycle tap on key 1 is shorter than the debounce window and must
    // produce no strobe at all.
    n_strobe1 = 0;
    applyStimulus(4'b1101, 1'b1);
    for (int j = 0; j < 20; j++) begin
      applyStimulus((j < 2) ? 4'b1101 : 4'b1111, 1'b1);
      if (o_press[1] | o_long[1] | o_repeat[1] | o_release[1] | o_held[1]) n_strobe1++;
    end
    checkOutput("tap_no_strobe", 32'(n_strobe1), 32'd0);

    // Keys 0 and 3 together. Enable is dropped on edges 31..35 and a reset
    // pulse is applied while the keys are PRESSED.
    applyStimulus(4'b0110, 1'b1);
    for (int j = 0; j < 58; j++) begin
      applyStimulus((j >= 56) ? 4'b1111 : 4'b0110, !((j + 1) >= 31 && (j + 1) <= 35));
      if (j >= 5 && j <= 7) begin
        checkOutput("simul_press", 32'(o_press), (j == 6) ? 32'h9 : 32'h0);
        checkOutput("simul_event", 32'(o_event), (j == 6) ? 32'h1 : 32'h0);
      end
      if (j == 26) checkOutput("simul_long", 32'(o_long), 32'h9);
      if (j == 30 || j == 32)
        checkOutput("enable_held", 32'(o_held), (j == 30) ? 32'h9 : 32'h0);
      if (j == 41 || j == 42)
        checkOutput("reenable_press", 32'(o_press), (j == 42) ? 32'h9 : 32'h0);
      if (j == 45) begin
        #2 rst_n = 1'b0;
        #1 checkAllZero("midhold_reset");
      end
      if (j == 46) rst_n = 1'b1;
      if (j == 52 || j == 53)
        checkOutput("post_reset_press", 32'(o_press), (j == 53) ? 32'h9 : 32'h0);
    end
    repeat (12) applyStimulus('1, 1'b1);

    // Randomized phase. Keys toggle slowly with single-cycle glitches on
    // top; enable drops and reset pulses are occasional.
    base = '1; dis_left = 0; rst_pend = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 59) == 0) base[k] = ~base[k];
        drv[k] = base[k] ^ ($urandom_range(0, 19) == 0);
      end
      if (dis_left > 0) begin
        en = 1'b0;
        dis_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        en = 1'b0;
        dis_left = int'($urandom_range(1, 7));
      end else begin
        en = 1'b1;
      end
      applyStimulus(drv, en);
      if (rst_pend) begin
        rst_n = 1'b1;
        rst_pend = 1'b0;
      end else if ($urandom_range(0, 1999) == 0) begin
        #2 rst_n = 1'b0;
        #1 checkAllZero("rand_reset");
        rst_pend = 1'b1;
      end
    end
    if (rst_pend) rst_n = 1'b1;
    repeat (4) applyStimulus('1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
